// File: rtl/ln_s1_ctrl_if.sv
// Per-group Ex/Ex2 result handshake from the Stage1 sequencer to Stage2.
interface ln_s1_ctrl_if;
    logic        o_stat_valid;
    logic        i_stat_ready;
    logic [21:0] o_stat_ex;
    logic [31:0] o_stat_ex2;
    logic [7:0]  o_stat_grp;

    modport master (output o_stat_valid, o_stat_ex, o_stat_ex2, o_stat_grp,
                    input  i_stat_ready);
    modport slave  (input  o_stat_valid, o_stat_ex, o_stat_ex2, o_stat_grp,
                    output i_stat_ready);
endinterface

// File: rtl/ln_s1_ctrl.sv
// LayerNorm Stage1 sequencer: streams N_ELEM-sample groups from SRAM into Stage1,
// writes x_norm back to the input buffer and hands Ex/Ex2 per group to Stage2.
module ln_s1_ctrl #(
    parameter int N_ELEM  = 8,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [7:0]        i_num_grp,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [1:0]        i_alpha,
    input  logic [7:0]        i_inv_n,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_s1_valid,
    output logic [7:0]        o_s1_x,
    output logic [1:0]        o_s1_alpha,
    output logic [7:0]        o_s1_inv_n,
    input  logic              i_s1_done,
    input  logic [21:0]       i_s1_ex,
    input  logic [31:0]       i_s1_ex2,
    input  logic [8:0]        i_s1_x_norm,
    output logic              o_buf_we,
    output logic [ADDR_W-1:0] o_buf_waddr,
    output logic [8:0]        o_buf_wdata,
    ln_s1_ctrl_if.master      stat
);
    localparam int KW     = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam int STAGES = 1;

    typedef enum logic [2:0] {IDLE, FEED, WAIT, OUT, GAP} state_t;

    state_t          state;
    logic [STAGES:0] vld_pipe;  // [0] read issued, [1] SRAM data present
    logic [KW-1:0]   k;
    logic [7:0]      num_grp;
    logic [7:0]      grp;
    logic [TW-1:0]   tmo;

    assign o_mem_rd    = vld_pipe[0];
    assign o_s1_valid  = vld_pipe[STAGES];
    assign o_buf_we    = vld_pipe[STAGES];
    assign o_s1_x      = vld_pipe[STAGES] ? i_mem_rdata : '0;
    assign o_buf_wdata = vld_pipe[STAGES] ? i_s1_x_norm : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state             <= IDLE;
            vld_pipe          <= '0;
            k                 <= '0;
            num_grp           <= '0;
            grp               <= '0;
            tmo               <= '0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_err             <= 1'b0;
            o_mem_addr        <= '0;
            o_buf_waddr       <= '0;
            o_s1_alpha        <= '0;
            o_s1_inv_n        <= '0;
            stat.o_stat_valid <= 1'b0;
            stat.o_stat_ex    <= '0;
            stat.o_stat_ex2   <= '0;
            stat.o_stat_grp   <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            o_buf_waddr        <= o_mem_addr;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        num_grp    <= i_num_grp;
                        o_mem_addr <= i_base_addr;
                        o_s1_alpha <= i_alpha;
                        o_s1_inv_n <= i_inv_n;
                        grp        <= '0;
                        k          <= '0;
                        if (i_num_grp == 8'd0) begin
                            o_done <= 1'b1;
                        end else begin
                            o_busy      <= 1'b1;
                            vld_pipe[0] <= 1'b1;
                            state       <= FEED;
                        end
                    end
                end
                FEED: begin
                    // Address keeps counting past the last read so the next group starts in place.
                    o_mem_addr <= o_mem_addr + 1'b1;
                    k          <= k + 1'b1;
                    tmo        <= '0;
                    if (k == KW'(N_ELEM - 1)) begin
                        vld_pipe[0] <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    // Done is only trusted once the last sample has left the pipe.
                    if (!vld_pipe[STAGES]) begin
                        if (i_s1_done) begin
                            stat.o_stat_valid <= 1'b1;
                            stat.o_stat_ex    <= i_s1_ex;
                            stat.o_stat_ex2   <= i_s1_ex2;
                            stat.o_stat_grp   <= grp;
                            state             <= OUT;
                        end else if (tmo == TW'(TIMEOUT - 2)) begin
                            o_err  <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            tmo <= tmo + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (stat.i_stat_ready) begin
                        stat.o_stat_valid <= 1'b0;
                        if (grp == num_grp - 8'd1) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            grp   <= grp + 8'd1;
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    vld_pipe[0] <= 1'b1;
                    k           <= '0;
                    state       <= FEED;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ln_s1_ctrl.md
Name: ln_s1_ctrl

Overview:
Sequencer for the LayerNorm Stage1 statistics datapath (Ex/Ex2 units behind a single Stage1 instance).
- On a start command it processes i_num_grp groups of N_ELEM int8 activations each.
- For each group it fetches the activations from the input SRAM and streams them into Stage1.
- It writes Stage1's zero-point-shifted samples (x_norm) back to the normalisation input buffer.
- It waits for Stage1 done, then hands per-group Ex/Ex2 to Stage2 over a valid/ready port.

Parameters:
N_ELEM, 8, elements per group (Stage1 sample count); power of two, 2..256
ADDR_W, 10, SRAM / buffer address width
TIMEOUT, 64, max cycles waiting for i_s1_done before error

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_start  in  1  command strobe, accepted only in IDLE
i_num_grp  in  8  groups to process
i_base_addr  in  ADDR_W  SRAM/buffer start address
i_alpha  in  2  Stage1 alpha, latched at start
i_inv_n  in  8  Stage1 1/C, latched at start
o_busy  out  1  high from accepted start until o_done/o_err
o_done  out  1  1-cycle pulse, all groups complete
o_err  out  1  1-cycle pulse, Stage1 timeout
o_mem_rd  out  1  SRAM read enable
o_mem_addr  out  ADDR_W  SRAM read address
i_mem_rdata  in  8  SRAM data, valid one cycle after o_mem_rd
o_s1_valid  out  1  Stage1 i_valid
o_s1_x  out  8  Stage1 i_x
o_s1_alpha  out  2  latched alpha
o_s1_inv_n  out  8  latched inv_n
i_s1_done  in  1  Stage1 done
i_s1_ex  in  22  Stage1 Ex, signed
i_s1_ex2  in  32  Stage1 Ex2, unsigned
i_s1_x_norm  in  9  Stage1 x_norm, signed
o_buf_we  out  1  input-buffer write enable
o_buf_waddr  out  ADDR_W  input-buffer write address
o_buf_wdata  out  9  = i_s1_x_norm
o_stat_valid  out  1  Ex/Ex2 result valid
i_stat_ready  in  1  Stage2 accepts result
o_stat_ex  out  22  captured Ex
o_stat_ex2  out  32  captured Ex2
o_stat_grp  out  8  group index of result

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: state IDLE; every output 0; counters and latched config 0. Asserting i_rst mid-operation aborts at the next edge; there is no o_done and no o_err.
- States: IDLE, FEED, WAIT, OUT, GAP.
- IDLE:
  - i_start=1 at edge t latches num_grp, base_addr, alpha and inv_n.
  - If num_grp=0: o_done pulses at t+1 and the block stays in IDLE.
  - Otherwise: FEED from t+1, o_busy=1.
  - i_start outside IDLE is ignored.
- FEED:
  - o_mem_rd=1 for exactly N_ELEM consecutive cycles.
  - o_mem_addr = base + grp*N_ELEM + k, k=0..N_ELEM-1, wrapping modulo 2^ADDR_W.
- Stage1 feed: o_s1_valid is o_mem_rd delayed one cycle, with o_s1_x = i_mem_rdata. This gives exactly N_ELEM contiguous valid cycles per group, with no bubbles.
- Write-back: o_buf_we = o_s1_valid in the same cycle. o_buf_waddr is the read address delayed one cycle. o_buf_wdata = i_s1_x_norm, combinational pass-through.
- FEED -> WAIT after the last read is issued.
- WAIT:
  - A timeout counter starts on the cycle after the last o_s1_valid.
  - When i_s1_done=1: capture i_s1_ex, i_s1_ex2 and the group index into the output registers, then go to OUT.
  - i_s1_done seen during FEED, or on the same cycle as the last valid, is ignored.
  - If the counter reaches TIMEOUT without done: o_err pulses, then IDLE with o_busy=0.
- OUT:
  - o_stat_valid=1 with the data held stable until i_stat_ready=1; the transfer completes on that edge.
  - Then: last group → o_done pulses, IDLE; otherwise → GAP.
- GAP: one idle cycle guaranteeing Stage1 returns to IDLE, then FEED for grp+1.
- Throughput per group: N_ELEM + 1 (read latency) + Stage1 done latency + 1 capture + ready wait + 1 gap.
- o_s1_alpha and o_s1_inv_n are held constant for the whole command.

Test Plan:
1. Single group, N_ELEM=8, base=0x010, SRAM holds 128..135, ready tied 1:
   - o_mem_addr 0x010..0x017 on consecutive cycles.
   - o_s1_valid 8 cycles.
   - o_buf_wdata 0..7 written to addresses 0x010..0x017.
   - One o_stat_valid with grp=0, then o_done.
2. num_grp=3 with ready backpressure (ready low 5 cycles each result):
   - o_stat_ex/ex2/grp hold stable while valid is high without ready.
   - grp values 0, 1, 2.
   - Addresses advance by 8 per group.
   - Exactly one GAP cycle between groups.
   - One o_done.
3. num_grp=0 → o_done at t+1; no o_mem_rd, no o_s1_valid.
4. Stage1 model never asserts done:
   - o_err pulses exactly TIMEOUT cycles after the last valid.
   - o_busy drops; no o_stat_valid.
5. base=0x3FC with ADDR_W=10 → read and write addresses 0x3FC..0x3FF, 0x000..0x003.
6. i_rst asserted during FEED:
   - All outputs 0 at the next edge; no o_done.
   - A fresh i_start afterwards completes a normal group.
   - A start pulsed during busy is ignored.
